// File: rtl/fpmu_pkg.sv
// Shared types and constants for the FPMU pin sequencer: states, byte slots,
// unload indices, the error pattern and the flag bit layout.
package fpmu_pkg;

  typedef logic [15:0] half_t;
  typedef logic [3:0]  flags_t;

  // Kept as plain constants so the encoding stays visible to legacy tooling.
  typedef logic [2:0] fpmu_state_t;
  localparam fpmu_state_t StLoad   = 3'd0;
  localparam fpmu_state_t StStart  = 3'd1;
  localparam fpmu_state_t StBusy   = 3'd2;
  localparam fpmu_state_t StUnload = 3'd3;
  localparam fpmu_state_t StErr    = 3'd4;

  localparam logic [1:0] SlotALo = 2'd0;
  localparam logic [1:0] SlotAHi = 2'd1;
  localparam logic [1:0] SlotBLo = 2'd2;
  localparam logic [1:0] SlotBHi = 2'd3;

  localparam logic [1:0] IdxResLo = 2'd0;
  localparam logic [1:0] IdxResHi = 2'd1;
  localparam logic [1:0] IdxFlags = 2'd2;

  localparam logic [7:0] ErrPattern = 8'hEE;

  localparam int unsigned FlagInvalid   = 3;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagInexact   = 0;

endpackage

// File: rtl/fpmu_seq_ctrl_if.sv
// Start/done handshake between the pin sequencer (master) and the multiply
// datapath (slave).
interface fpmu_seq_ctrl_if;
  import fpmu_pkg::*;

  logic   dp_start;
  half_t  dp_a;
  half_t  dp_b;
  logic   dp_done;
  half_t  dp_result;
  flags_t dp_flags;

  modport master (
    output dp_start, dp_a, dp_b,
    input  dp_done, dp_result, dp_flags
  );

  modport slave (
    input  dp_start, dp_a, dp_b,
    output dp_done, dp_result, dp_flags
  );

endinterface

// File: rtl/fpmu_strobe_sync.sv
// Synchronizes an asynchronous pin and emits a one-cycle pulse per rising edge.
// A pin already high when reset is released never produces a pulse.
module fpmu_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic                   prev_q;
  logic                   pulse_q;
  logic                   sync_out;
  logic                   sync_valid;

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign sync_valid = valid_q[SYNC_STAGES-1];
  assign pulse      = pulse_q;

  // valid_q tracks which chain stages hold real pin samples; until the output
  // stage does, prev_q is held high so no edge can be inferred from reset zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      valid_q <= '0;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(pin);
      valid_q <= (valid_q << 1) | SYNC_STAGES'(1'b1);
      prev_q  <= sync_valid ? sync_out : 1'b1;
      pulse_q <= sync_valid & sync_out & ~prev_q;
    end
  end

endmodule

// File: rtl/fpmu_seq_ctrl.sv
// Byte-serial operand loader / result unloader in front of the FPMU multiplier.
// Define FPMU_TIMEOUT_EN to add the busy-wait timeout and the ERR state.
module fpmu_seq_ctrl
  import fpmu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic       abort,
  output logic [7:0] dout,
  output logic [1:0] byte_idx,
  output logic       busy,
  output logic       ready,
  output logic       error,
  fpmu_seq_ctrl_if.master dp
);

  logic wr_p, rd_p, ab_p;

  fpmu_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .reset(reset), .pin(wr_stb), .pulse(wr_p)
  );
  fpmu_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .reset(reset), .pin(rd_stb), .pulse(rd_p)
  );
  fpmu_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ab_sync (
    .clk(clk), .reset(reset), .pin(abort), .pulse(ab_p)
  );

  fpmu_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  half_t       a_q, a_d, b_q, b_d, res_q, res_d;
  flags_t      flags_q, flags_d;

`ifdef FPMU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
`ifdef FPMU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (ab_p) begin
      state_d = StLoad;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        StLoad: begin
          if (wr_p) begin
            unique case (idx_q)
              SlotALo: a_d[7:0]  = din;
              SlotAHi: a_d[15:8] = din;
              SlotBLo: b_d[7:0]  = din;
              SlotBHi: b_d[15:8] = din;
            endcase
            idx_d = idx_q + 2'd1;
            if (idx_q == SlotBHi) state_d = StStart;
          end
        end
        StStart: begin
          state_d = StBusy;
`ifdef FPMU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
        StBusy: begin
          // A done pulse in the limit cycle still wins over the timeout.
          if (dp.dp_done) begin
            res_d   = dp.dp_result;
            flags_d = dp.dp_flags;
            state_d = StUnload;
            idx_d   = 2'd0;
          end
`ifdef FPMU_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StErr;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        StUnload: begin
          if (rd_p) begin
            if (idx_q == IdxFlags) begin
              state_d = StLoad;
              idx_d   = 2'd0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
`ifdef FPMU_TIMEOUT_EN
        StErr: begin
          if (rd_p) begin
            state_d = StLoad;
            idx_d   = 2'd0;
          end
        end
`endif
        default: begin
          state_d = StLoad;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      idx_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
`ifdef FPMU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
`ifdef FPMU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    dout = 8'h00;
    case (state_q)
      StUnload: begin
        case (idx_q)
          IdxResLo: dout = res_q[7:0];
          IdxResHi: dout = res_q[15:8];
          IdxFlags: dout = {4'b0000, flags_q};
          default:  dout = 8'h00;
        endcase
      end
      StErr:   dout = ErrPattern;
      default: dout = 8'h00;
    endcase
  end

  assign byte_idx    = idx_q;
  assign busy        = (state_q == StStart) || (state_q == StBusy);
  assign ready       = (state_q == StUnload);
`ifdef FPMU_TIMEOUT_EN
  assign error       = (state_q == StErr);
`else
  assign error       = 1'b0;
`endif
  assign dp.dp_start = (state_q == StStart);
  assign dp.dp_a     = a_q;
  assign dp.dp_b     = b_q;

endmodule

// File: tb/tb_fpmu_seq_ctrl.sv
// Directed self-checking bench for fpmu_seq_ctrl; the datapath is mocked by
// driving the slave side of the handshake interface.
module tb_fpmu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr_stb = 1'b0;
  logic       rd_stb = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] dout;
  logic [1:0] byte_idx;
  logic       busy, ready, error;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  fpmu_seq_ctrl_if dp_if ();

  fpmu_seq_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .abort(abort), .dout(dout), .byte_idx(byte_idx), .busy(busy), .ready(ready),
    .error(error), .dp(dp_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dp_if.dp_start === 1'b1) start_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    din = b; wr_stb = 1'b1; tick(2); wr_stb = 1'b0; tick(5);
  endtask

  task automatic rd_edge();
    rd_stb = 1'b1; tick(2); rd_stb = 1'b0; tick(5);
  endtask

  task automatic abort_edge();
    abort = 1'b1; tick(2); abort = 1'b0; tick(5);
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick(3); reset = 1'b0; tick(1);
  endtask

  // Loads four bytes and returns sampling the first BUSY cycle.
  task automatic load_launch(input logic [15:0] a, input logic [15:0] b);
    int s0;
    bit seen;
    s0 = start_cnt;
    seen = 1'b0;
    wr_byte(a[7:0]); wr_byte(a[15:8]); wr_byte(b[7:0]);
    din = b[15:8]; wr_stb = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      if (dp_if.dp_start === 1'b1) seen = 1'b1;
    end
    wr_stb = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL launch_start_timeout: dp_start never seen, expected one pulse");
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: busy=%b expected 1", busy); end
    tick(1);
    checks++;
    if (dp_if.dp_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_entry: dp_start=%b busy=%b expected 0/1", dp_if.dp_start, busy);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++; $display("FAIL start_pulse_count: got %0d expected 1", start_cnt - s0);
    end
    checks++;
    if (dp_if.dp_a !== a || dp_if.dp_b !== b) begin
      errors++;
      $display("FAIL operands: a=%h b=%h expected %h %h", dp_if.dp_a, dp_if.dp_b, a, b);
    end
  endtask

  task automatic pulse_done(input logic [15:0] r, input logic [3:0] f);
    dp_if.dp_result = r; dp_if.dp_flags = f; dp_if.dp_done = 1'b1;
    tick(1);
    dp_if.dp_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dout !== 8'h00 || byte_idx !== 2'd0) begin
      errors++; $display("FAIL reset_dout_idx: dout=%h idx=%0d expected 00/0", dout, byte_idx);
    end
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || error !== 1'b0 || dp_if.dp_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b ready=%b error=%b start=%b expected 0000",
               busy, ready, error, dp_if.dp_start);
    end
    checks++;
    if (dp_if.dp_a !== 16'h0000 || dp_if.dp_b !== 16'h0000) begin
      errors++;
      $display("FAIL reset_operands: a=%h b=%h expected 0000", dp_if.dp_a, dp_if.dp_b);
    end
  endtask

  task automatic test_basic();
    wr_byte(8'h00);
    checks++;
    if (byte_idx !== 2'd1) begin errors++; $display("FAIL idx_after_1: got %0d expected 1", byte_idx); end
    wr_byte(8'h3C);
    checks++;
    if (byte_idx !== 2'd2) begin errors++; $display("FAIL idx_after_2: got %0d expected 2", byte_idx); end
    wr_byte(8'h00);
    checks++;
    if (byte_idx !== 2'd3) begin errors++; $display("FAIL idx_after_3: got %0d expected 3", byte_idx); end
    din = 8'h40; wr_stb = 1'b1;
    for (int i = 0; i < 12 && busy !== 1'b1; i++) tick(1);
    wr_stb = 1'b0;
    checks++;
    if (dp_if.dp_start !== 1'b1 || byte_idx !== 2'd0) begin
      errors++;
      $display("FAIL start_cycle: start=%b idx=%0d expected 1/0", dp_if.dp_start, byte_idx);
    end
    tick(1);
    checks++;
    if (dp_if.dp_start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_one_cycle: start=%b busy=%b expected 0/1", dp_if.dp_start, busy);
    end
    checks++;
    if (dp_if.dp_a !== 16'h3C00 || dp_if.dp_b !== 16'h4000) begin
      errors++; $display("FAIL basic_ops: a=%h b=%h expected 3c00 4000", dp_if.dp_a, dp_if.dp_b);
    end
    tick(4);
    checks++;
    if (ready !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL busy_outputs: ready=%b dout=%h expected 0/00", ready, dout);
    end
    pulse_done(16'h4000, 4'h0);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || dout !== 8'h00 || byte_idx !== 2'd0) begin
      errors++;
      $display("FAIL unload_0: ready=%b busy=%b dout=%h idx=%0d expected 1/0/00/0",
               ready, busy, dout, byte_idx);
    end
    rd_edge();
    checks++;
    if (dout !== 8'h40 || byte_idx !== 2'd1) begin
      errors++; $display("FAIL unload_1: dout=%h idx=%0d expected 40/1", dout, byte_idx);
    end
    rd_edge();
    checks++;
    if (dout !== 8'h00 || byte_idx !== 2'd2) begin
      errors++; $display("FAIL unload_2: dout=%h idx=%0d expected 00/2", dout, byte_idx);
    end
    rd_edge();
    checks++;
    if (ready !== 1'b0 || byte_idx !== 2'd0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL unload_exit: ready=%b idx=%0d dout=%h expected 0/0/00", ready, byte_idx, dout);
    end
  endtask

  task automatic test_flags_result();
    load_launch(16'h2211, 16'h4433);
    tick(2);
    pulse_done(16'hA5C3, 4'hB);
    checks++;
    if (dout !== 8'hC3) begin errors++; $display("FAIL res_lo: got %h expected c3", dout); end
    rd_edge();
    checks++;
    if (dout !== 8'hA5) begin errors++; $display("FAIL res_hi: got %h expected a5", dout); end
    rd_edge();
    checks++;
    if (dout !== 8'h0B) begin errors++; $display("FAIL flags_byte: got %h expected 0b", dout); end
    rd_edge();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL flags_exit: ready=%b expected 0", ready); end
  endtask

  task automatic test_rd_in_load();
    rd_edge(); rd_edge(); rd_edge();
    checks++;
    if (dout !== 8'h00 || byte_idx !== 2'd0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_in_load: dout=%h idx=%0d ready=%b expected 00/0/0", dout, byte_idx, ready);
    end
    load_launch(16'h1357, 16'h9BDF);
    pulse_done(16'h0001, 4'h1);
    rd_edge(); rd_edge(); rd_edge();
  endtask

  task automatic test_abort();
    wr_byte(8'hAA); wr_byte(8'hBB);
    checks++;
    if (byte_idx !== 2'd2) begin errors++; $display("FAIL pre_abort_idx: got %0d expected 2", byte_idx); end
    abort_edge();
    checks++;
    if (byte_idx !== 2'd0 || dp_if.dp_a !== 16'hBBAA) begin
      errors++;
      $display("FAIL abort_load: idx=%0d a=%h expected 0/bbaa", byte_idx, dp_if.dp_a);
    end
    load_launch(16'h0201, 16'h0403);
    abort_edge();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL abort_busy: busy=%b ready=%b expected 0/0", busy, ready);
    end
    pulse_done(16'hFFFF, 4'hF);
    tick(1);
    checks++;
    if (ready !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL late_done: ready=%b dout=%h expected 0/00", ready, dout);
    end
  endtask

  task automatic test_ignored_events();
    load_launch(16'h5566, 16'h7788);
    wr_byte(8'hFF);
    checks++;
    if (dp_if.dp_a !== 16'h5566 || byte_idx !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_in_busy: a=%h idx=%0d busy=%b expected 5566/0/1",
               dp_if.dp_a, byte_idx, busy);
    end
    pulse_done(16'h1234, 4'h2);
    wr_byte(8'hEE);
    checks++;
    if (dout !== 8'h34 || byte_idx !== 2'd0 || dp_if.dp_a !== 16'h5566) begin
      errors++;
      $display("FAIL wr_in_unload: dout=%h idx=%0d a=%h expected 34/0/5566",
               dout, byte_idx, dp_if.dp_a);
    end
    rd_edge(); rd_edge(); rd_edge();
    pulse_done(16'h9999, 4'h9);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_in_load: ready=%b busy=%b expected 0/0", ready, busy);
    end
  endtask

  task automatic test_held_reset();
    reset = 1'b1; din = 8'h77; wr_stb = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    checks++;
    if (byte_idx !== 2'd0 || dp_if.dp_a !== 16'h0000) begin
      errors++;
      $display("FAIL held_reset: idx=%0d a=%h expected 0/0000", byte_idx, dp_if.dp_a);
    end
    wr_stb = 1'b0;
    tick(5);
  endtask

`ifdef FPMU_TIMEOUT_EN
  task automatic test_timeout();
    load_launch(16'h0102, 16'h0304);
    tick(63);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_timeout: error=%b busy=%b expected 0/1", error, busy);
    end
    tick(1);
    checks++;
    if (error !== 1'b1 || dout !== 8'hEE || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout: error=%b dout=%h busy=%b ready=%b expected 1/ee/0/0",
               error, dout, busy, ready);
    end
    rd_edge();
    checks++;
    if (error !== 1'b0 || dout !== 8'h00 || byte_idx !== 2'd0) begin
      errors++;
      $display("FAIL err_exit: error=%b dout=%h idx=%0d expected 0/00/0", error, dout, byte_idx);
    end
  endtask

  task automatic test_done_at_limit();
    load_launch(16'h0A0B, 16'h0C0D);
    tick(63);
    pulse_done(16'h5A3C, 4'h4);
    checks++;
    if (ready !== 1'b1 || error !== 1'b0 || dout !== 8'h3C) begin
      errors++;
      $display("FAIL done_at_limit: ready=%b error=%b dout=%h expected 1/0/3c",
               ready, error, dout);
    end
    rd_edge(); rd_edge(); rd_edge();
  endtask
`else
  task automatic test_no_timeout();
    load_launch(16'h0102, 16'h0304);
    tick(100);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_forever: busy=%b error=%b ready=%b expected 1/0/0", busy, error, ready);
    end
    pulse_done(16'h00AB, 4'h0);
    checks++;
    if (ready !== 1'b1 || dout !== 8'hAB) begin
      errors++; $display("FAIL late_result: ready=%b dout=%h expected 1/ab", ready, dout);
    end
    rd_edge(); rd_edge(); rd_edge();
  endtask
`endif

  initial begin
    dp_if.dp_done = 1'b0;
    dp_if.dp_result = 16'h0000;
    dp_if.dp_flags = 4'h0;
    test_reset();
    test_basic();
    test_flags_result();
    test_rd_in_load();
    test_abort();
    test_ignored_events();
    test_held_reset();
`ifdef FPMU_TIMEOUT_EN
    test_timeout();
    test_done_at_limit();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
